keyboard_decoder: RTL and testbench

KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

---
 rtl/keyboard_decoder_pkg.sv | 31 +++
 rtl/keyboard_decoder_ps2_rx.sv | 69 ++++++
 rtl/keyboard_decoder.sv | 85 ++++++++
 tb/tb_keyboard_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/keyboard_decoder_pkg.sv
// Shared PS/2 keyboard constants: prefix/non-key bytes, prefix-FSM encoding, key codes.
package keyboard_decoder_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned KEYS_N  = 128;
    localparam int unsigned STATE_W = 2;

    localparam logic [BYTE_W-1:0] BYTE_E0 = 8'hE0;
    localparam logic [BYTE_W-1:0] BYTE_F0 = 8'hF0;
    localparam logic [BYTE_W-1:0] BYTE_AA = 8'hAA;
    localparam logic [BYTE_W-1:0] BYTE_E1 = 8'hE1;
    localparam logic [BYTE_W-1:0] BYTE_EE = 8'hEE;
    localparam logic [BYTE_W-1:0] BYTE_FA = 8'hFA;
    localparam logic [BYTE_W-1:0] BYTE_FC = 8'hFC;
    localparam logic [BYTE_W-1:0] BYTE_FE = 8'hFE;

    localparam logic [BYTE_W-1:0] KEY_BACK  = 8'h66;
    localparam logic [BYTE_W-1:0] KEY_SPACE = 8'h29;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_EXT     = 2'd1;
    localparam logic [STATE_W-1:0] ST_BRK     = 2'd2;
    localparam logic [STATE_W-1:0] ST_EXT_BRK = 2'd3;

    // Keyboard status/ack bytes that never describe a key.
    function automatic logic is_non_key(input logic [BYTE_W-1:0] b);
        return (b == BYTE_AA) || (b == BYTE_E1) || (b == BYTE_EE) ||
               (b == BYTE_FA) || (b == BYTE_FC) || (b == BYTE_FE);
    endfunction

endpackage

// File: rtl/keyboard_decoder_ps2_rx.sv
// PS/2 receiver: line synchronizers, falling-edge detect, 11-bit frame shifter,
// frame check and inter-edge timeout. Results are valid in the stop-bit edge cycle.
module ps2_rx #(
    parameter int unsigned TIMEOUT = 131072
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte_c,
    output logic       byte_valid_c,
    output logic       frame_err_c
);

    localparam int unsigned TMR_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = 4'd10;

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_prev;
    logic [CNT_W-1:0] bit_cnt;
    logic [9:0]       shift;
    logic [TMR_W-1:0] tmr;

    logic fall_c;
    logic stop_c;
    logic frame_ok_c;

    assign fall_c = clk_prev & ~clk_sync[1];
    assign stop_c = fall_c && (bit_cnt == LAST_BIT);

    // shift[0]=start, shift[8:1]=data, shift[9]=parity; stop bit is the live sample.
    assign frame_ok_c   = ~shift[0] & data_sync[1] & (^shift[9:1]);
    assign rx_byte_c    = shift[8:1];
    assign byte_valid_c = stop_c & frame_ok_c;
    assign frame_err_c  = stop_c & ~frame_ok_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
            bit_cnt   <= '0;
            shift     <= '0;
            tmr       <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
            if (fall_c) begin
                shift   <= {data_sync[1], shift[9:1]};
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 4'd1;
                tmr     <= '0;
            end else if (bit_cnt != '0) begin
                // Stalled partial frame: drop it so the next start bit realigns.
                if (tmr == TMR_W'(TIMEOUT - 1)) begin
                    bit_cnt <= '0;
                    tmr     <= '0;
                end else begin
                    tmr <= tmr + TMR_W'(1);
                end
            end else begin
                tmr <= '0;
            end
        end
    end

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard decoder: E0/F0 prefix FSM over received bytes, per-key held flags
// and make/break event reporting.
module keyboard_decoder
    import keyboard_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT = 131072
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    output logic [127:0]  key_down,
    output logic [8:0]    last_change,
    output logic          key_valid,
    output logic          parity_err
);

    logic [BYTE_W-1:0]  rx_byte_c;
    logic               byte_valid_c;
    logic               frame_err_c;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               key_evt_c;
    logic               extend_c;
    logic               make_c;

    ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_byte_c    (rx_byte_c),
        .byte_valid_c (byte_valid_c),
        .frame_err_c  (frame_err_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Prefix tracking; dropped frames never reach here, so the state holds on errors.
    always_comb begin
        state_d   = state_q;
        key_evt_c = 1'b0;
        extend_c  = 1'b0;
        make_c    = 1'b0;
        if (byte_valid_c) begin
            if (rx_byte_c == BYTE_E0) begin
                if (state_q == ST_IDLE) state_d = ST_EXT;
            end else if (rx_byte_c == BYTE_F0) begin
                case (state_q)
                    ST_IDLE: state_d = ST_BRK;
                    ST_EXT:  state_d = ST_EXT_BRK;
                    default: state_d = state_q;
                endcase
            end else if (is_non_key(rx_byte_c)) begin
                state_d = ST_IDLE;
            end else begin
                key_evt_c = 1'b1;
                extend_c  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
                make_c    = (state_q == ST_IDLE) || (state_q == ST_EXT);
                state_d   = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_down    <= '0;
            last_change <= '0;
            key_valid   <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            key_valid  <= key_evt_c;
            parity_err <= frame_err_c;
            if (key_evt_c) begin
                last_change <= {extend_c, rx_byte_c};
                if (!extend_c && !rx_byte_c[7]) key_down[rx_byte_c[6:0]] <= make_c;
            end
        end
    end

endmodule

// File: tb/tb_keyboard_decoder.sv
// Self-checking bench for keyboard_decoder: directed scenarios plus random byte
// streams compared against a prefix-flag reference model.
module tb_keyboard_decoder;

    localparam int unsigned TIMEOUT = 100;
    localparam int unsigned HALF    = 8;
    localparam int unsigned GAP     = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ps2_clk = 1'b1;
    logic         ps2_data = 1'b1;
    logic [127:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         parity_err;

    int n_checks = 0;
    int n_errors = 0;
    int kv_cycles = 0;
    int pe_cycles = 0;

    // Reference model state: pending prefixes as plain flags.
    bit           m_ext = 1'b0;
    bit           m_brk = 1'b0;
    logic [8:0]   m_last = '0;
    logic [127:0] m_keys = '0;

    logic [7:0] non_keys [6] = '{8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE};

    keyboard_decoder #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid)  kv_cycles = kv_cycles + 1;
        if (parity_err) pe_cycles = pe_cycles + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_non_keys(input logic [7:0] b);
        foreach (non_keys[i]) if (non_keys[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit bad, output bit ev);
        ev = 1'b0;
        if (bad) return;
        if (b == 8'hE0) begin
            if (!m_ext && !m_brk) m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (in_non_keys(b)) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            ev = 1'b1;
            m_last = {m_ext, b};
            if (!m_ext && b < 8'h80) m_keys[b[6:0]] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~(^b)) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bad);
        int kv0;
        int pe0;
        bit ev;
        kv0 = kv_cycles;
        pe0 = pe_cycles;
        send_bits(b, bad, 11);
        repeat (GAP) @(posedge clk);
        #1;
        model_byte(b, bad, ev);
        check($sformatf("key_valid_cnt[%0h]", b), 128'(kv_cycles - kv0), 128'(ev));
        check($sformatf("parity_err_cnt[%0h]", b), 128'(pe_cycles - pe0), 128'(bad));
        check($sformatf("last_change[%0h]", b), 128'(last_change), 128'(m_last));
        check($sformatf("key_down[%0h]", b), key_down, m_keys);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key_down"}, key_down, 128'(0));
        check({tag, "_last_change"}, 128'(last_change), 128'(0));
        check({tag, "_key_valid"}, 128'(key_valid), 128'(0));
        check({tag, "_parity_err"}, 128'(parity_err), 128'(0));
    endtask

    initial begin
        logic [7:0] b;
        bit bad;
        int r;

        repeat (4) @(posedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (5) @(posedge clk);

        // Make, break, extended make/break.
        do_frame(8'h1C, 1'b0);
        do_frame(8'hF0, 1'b0);
        do_frame(8'h1C, 1'b0);
        do_frame(8'hE0, 1'b0);
        do_frame(8'h75, 1'b0);
        do_frame(8'hE0, 1'b0);
        do_frame(8'hF0, 1'b0);
        do_frame(8'h75, 1'b0);

        // Bad parity is dropped, then the same key decodes; typematic repeat.
        do_frame(8'h29, 1'b1);
        do_frame(8'h29, 1'b0);
        do_frame(8'h29, 1'b0);

        // Stalled partial frame is discarded by the timeout.
        send_bits(8'h12, 1'b0, 5);
        repeat (TIMEOUT + 10) @(posedge clk);
        do_frame(8'h66, 1'b0);

        // Bytes >= 0x80 report but do not touch key_down; non-key clears prefix.
        do_frame(8'h83, 1'b0);
        do_frame(8'hE0, 1'b0);
        do_frame(8'hFA, 1'b0);
        do_frame(8'h15, 1'b0);

        // Reset in the middle of a frame with keys held.
        do_frame(8'h1C, 1'b0);
        do_frame(8'h32, 1'b0);
        send_bits(8'h55, 1'b0, 4);
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        #1;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_last = '0;
        m_keys = '0;
        check_all_zero("midframe_reset");
        repeat (GAP) @(posedge clk);
        do_frame(8'h32, 1'b0);

        // Random byte stream weighted toward prefixes and status bytes.
        for (int n = 0; n < 120; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else if (r == 2) b = non_keys[$urandom_range(0, 5)];
            else             b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 9) == 0);
            do_frame(b, bad);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
